switch_cfu_ord: RTL and testbench
=================================

Name: switch_cfu_ord

Overview:
- CFU-L2 switch, successor to the single-target-per-initiator switch: connects N_INIS initiators to N_TGTS target CFUs.
- Each initiator may have requests in flight to several targets at once. Responses still return to each initiator strictly in its request order.
- Upper CFU-ID bits select the target. Lower LEAF_CFU_ID_W bits pass through to the target, so targets may themselves be switches.
- An out-of-range CFU ID gets an error response from the switch itself.

Parameters:
- CFU_CFU_ID_W, 4, CFU ID width.
- CFU_STATE_ID_W, 1, state ID width.
- CFU_FUNC_ID_W, 10, function ID width.
- CFU_INSN_W, 1, insn width (min 1).
- CFU_DATA_W, 32, data width.
- CFU_STATUS_W, 3, status width.
- N_INIS, 2, number of initiators (≥1).
- N_TGTS, 2, number of targets (≥1, ≤2^(CFU_CFU_ID_W-LEAF_CFU_ID_W)).
- LEAF_CFU_ID_W, 0, low CFU-ID bits forwarded to the target (0..CFU_CFU_ID_W-1).
- N_REQS, 4, max in-flight requests per initiator and per target (power of 2, ≥2).
- BAD_CFU_STATUS, 2, status returned for an out-of-range CFU ID.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clk_en  in  1  clock enable; no state change when 0
- i_req_valids / i_req_readys  in / out  N_INIS  initiator request handshake
- i_req_cfus  in  N_INIS*CFU_CFU_ID_W  request CFU ID
- i_req_states  in  N_INIS*CFU_STATE_ID_W  request state ID
- i_req_funcs  in  N_INIS*CFU_FUNC_ID_W  request function ID
- i_req_insns  in  N_INIS*CFU_INSN_W  request insn
- i_req_data0s / i_req_data1s  in  N_INIS*CFU_DATA_W  request operands
- i_resp_valids / i_resp_readys  out / in  N_INIS  initiator response handshake
- i_resp_statuss  out  N_INIS*CFU_STATUS_W  response status
- i_resp_datas  out  N_INIS*CFU_DATA_W  response data
- t_req_* (valids, readys, cfus, states, funcs, insns, data0s, data1s)  mirror of i_req_*, N_TGTS wide, directions reversed
- t_resp_* (valids, readys, statuss, datas)  mirror of i_resp_*, N_TGTS wide, directions reversed

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset clears all queues, round-robin pointers, and every output register to 0 (t_req_valids=0, i_resp_valids=0).
- Target select: tsel = i_req_cfus[i] >> LEAF_CFU_ID_W. Forwarded t_req_cfus = low LEAF_CFU_ID_W bits of the request CFU ID, upper bits 0.
- Queues: per-initiator order FIFO (depth N_REQS) of target index; per-target FIFO (depth N_REQS) of initiator index.
- Request eligibility for initiator i to target t: i_req_valid, tsel==t<N_TGTS, i's order FIFO not full, t's FIFO not full, and t_req port available (~t_req_valid | t_req_ready).
- Arbitration: per target, round-robin among eligible initiators, starting after the last-granted initiator. An initiator is granted at most once per cycle.
- On grant, in the same cycle: i_req_ready=1, push t onto i's FIFO, push i onto t's FIFO. The request is registered to the t_req outputs (1-cycle latency).
- t_req_valid holds until t_req_ready is seen. A fresh grant may overwrite it in the same cycle as its handshake.
- Response routing: target t's response goes to initiator i iff head(t)==i, head(i)==t, and i's response register is available (~i_resp_valid | i_resp_ready).
  - In that case: t_resp_ready[t]=1, pop both FIFOs, register status/data to i (1-cycle latency).
- Bad CFU (tsel ≥ N_TGTS): accepted only when i's order FIFO is empty and i's response register is available.
  - Next cycle: i_resp_valid=1, status=BAD_CFU_STATUS, data=0. Never forwarded to any target.
  - Otherwise i_req_ready stays 0.
- Deadlock-free: the globally oldest in-flight request is always at the head of both its FIFOs.
- Simultaneous push and pop on the same FIFO is allowed. A full FIFO with a same-cycle pop still does not accept a push (fullness is judged on the registered count).
- Reset mid-transaction discards all in-flight state; targets are reset alongside the switch.

Optional Feature:
- Macro SWITCH_CFU_ORD_STRICT_EN.
  - Defined: legacy eligibility. An initiator may issue to t only if it has 0 in flight, or all of its in-flight requests target t (and its FIFO is not full). Initiator FIFOs may then be replaced by one target register plus a counter.
  - Undefined: multi-target issue as described above.

Test Plan:
- N_INIS=1: issue cfu=0 then cfu=1 back-to-back; target1 responds at cycle 3, target0 at cycle 8 -> initiator sees target0 data first, then target1. Both requests are on the t_req ports before either response.
- Same as above with SWITCH_CFU_ORD_STRICT_EN -> second request held (i_req_ready=0) until target0's response pops.
- N_INIS=2, both send continuously to cfu=0 -> grants alternate 0,1,0,1; each response returns to its originator.
- Target 0 holds t_resp_valid=0 while initiator 0 issues 4 requests to it -> 5th request stalls (i_req_ready=0) until 1 response is delivered.
- N_TGTS=2, LEAF_CFU_ID_W=2, cfu=4'b0110 -> sent to target 1 with t_req_cfus=2. cfu=4'b1100 with empty queue -> status 2, data 0 one cycle later.
- Assert rst with 3 requests in flight -> all valids 0 next cycle; a new request after reset completes normally.

Source files
------------

// File: rtl/switch_cfu_ord.sv
// switch_cfu_ord: CFU-L2 switch connecting N_INIS initiators to N_TGTS target CFUs.
// Each initiator may have requests in flight to several targets. Responses return to
// each initiator in its own request order, tracked by per-initiator and per-target FIFOs.
// Optional macro SWITCH_CFU_ORD_STRICT_EN: an initiator only issues to a single target at a time.
module switch_cfu_ord #(
    parameter int CFU_CFU_ID_W   = 4,
    parameter int CFU_STATE_ID_W = 1,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_INSN_W     = 1,
    parameter int CFU_DATA_W     = 32,
    parameter int CFU_STATUS_W   = 3,
    parameter int N_INIS         = 2,
    parameter int N_TGTS         = 2,
    parameter int LEAF_CFU_ID_W  = 0,
    parameter int N_REQS         = 4,
    parameter int BAD_CFU_STATUS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clk_en,
    input  logic [N_INIS-1:0]                  i_req_valids,
    output logic [N_INIS-1:0]                  i_req_readys,
    input  logic [N_INIS*CFU_CFU_ID_W-1:0]     i_req_cfus,
    input  logic [N_INIS*CFU_STATE_ID_W-1:0]   i_req_states,
    input  logic [N_INIS*CFU_FUNC_ID_W-1:0]    i_req_funcs,
    input  logic [N_INIS*CFU_INSN_W-1:0]       i_req_insns,
    input  logic [N_INIS*CFU_DATA_W-1:0]       i_req_data0s,
    input  logic [N_INIS*CFU_DATA_W-1:0]       i_req_data1s,
    output logic [N_INIS-1:0]                  i_resp_valids,
    input  logic [N_INIS-1:0]                  i_resp_readys,
    output logic [N_INIS*CFU_STATUS_W-1:0]     i_resp_statuss,
    output logic [N_INIS*CFU_DATA_W-1:0]       i_resp_datas,
    output logic [N_TGTS-1:0]                  t_req_valids,
    input  logic [N_TGTS-1:0]                  t_req_readys,
    output logic [N_TGTS*CFU_CFU_ID_W-1:0]     t_req_cfus,
    output logic [N_TGTS*CFU_STATE_ID_W-1:0]   t_req_states,
    output logic [N_TGTS*CFU_FUNC_ID_W-1:0]    t_req_funcs,
    output logic [N_TGTS*CFU_INSN_W-1:0]       t_req_insns,
    output logic [N_TGTS*CFU_DATA_W-1:0]       t_req_data0s,
    output logic [N_TGTS*CFU_DATA_W-1:0]       t_req_data1s,
    input  logic [N_TGTS-1:0]                  t_resp_valids,
    output logic [N_TGTS-1:0]                  t_resp_readys,
    input  logic [N_TGTS*CFU_STATUS_W-1:0]     t_resp_statuss,
    input  logic [N_TGTS*CFU_DATA_W-1:0]       t_resp_datas
);
    localparam int TI_W = (N_TGTS > 1) ? $clog2(N_TGTS) : 1;
    localparam int II_W = (N_INIS > 1) ? $clog2(N_INIS) : 1;
    localparam int PW   = $clog2(N_REQS);
    localparam int CW   = PW + 1;
    localparam int XW   = CFU_CFU_ID_W + 1;
    localparam logic [CFU_CFU_ID_W-1:0] LEAF_MASK = CFU_CFU_ID_W'((1 << LEAF_CFU_ID_W) - 1);

    // Queue state: per-initiator order of targets, per-target order of initiators
    logic [TI_W-1:0] r_ofifo  [N_INIS][N_REQS];
    logic [PW-1:0]   r_ord_rd [N_INIS];
    logic [PW-1:0]   r_ord_wr [N_INIS];
    logic [CW-1:0]   r_ord_cnt[N_INIS];
    logic [II_W-1:0] r_tq     [N_TGTS][N_REQS];
    logic [PW-1:0]   r_tq_rd  [N_TGTS];
    logic [PW-1:0]   r_tq_wr  [N_TGTS];
    logic [CW-1:0]   r_tq_cnt [N_TGTS];
    logic [II_W-1:0] r_rr     [N_TGTS];

    logic [N_TGTS-1:0]                r_t_req_valids;
    logic [N_TGTS*CFU_CFU_ID_W-1:0]   r_t_req_cfus;
    logic [N_TGTS*CFU_STATE_ID_W-1:0] r_t_req_states;
    logic [N_TGTS*CFU_FUNC_ID_W-1:0]  r_t_req_funcs;
    logic [N_TGTS*CFU_INSN_W-1:0]     r_t_req_insns;
    logic [N_TGTS*CFU_DATA_W-1:0]     r_t_req_data0s;
    logic [N_TGTS*CFU_DATA_W-1:0]     r_t_req_data1s;
    logic [N_INIS-1:0]                r_i_resp_valids;
    logic [N_INIS*CFU_STATUS_W-1:0]   r_i_resp_statuss;
    logic [N_INIS*CFU_DATA_W-1:0]     r_i_resp_datas;

    logic [XW-1:0]           w_tsel     [N_INIS];
    logic [CFU_CFU_ID_W-1:0] w_fwd_cfu  [N_INIS];
    logic [TI_W-1:0]         w_ohead    [N_INIS];
    logic [N_INIS-1:0]       w_bad, w_ofull, w_oempty, w_resp_avail, w_strict_ok, w_bad_acc;
    logic [N_INIS-1:0]       w_gnt_ini, w_resp_pop;
    logic [II_W-1:0]         w_thead    [N_TGTS];
    logic [N_INIS-1:0]       w_elig     [N_TGTS];
    logic [N_INIS-1:0]       w_gnt      [N_TGTS];
    logic [II_W-1:0]         w_gnt_idx  [N_TGTS];
    logic [N_TGTS-1:0]       w_tfull, w_tavail, w_route;

    // Round-robin pick: first requester after the last-granted index, then wrap
    function automatic logic [N_INIS-1:0] rr_pick(input logic [N_INIS-1:0] req, input int last);
        logic [N_INIS-1:0] g;
        g = '0;
        for (int i = 0; i < N_INIS; i++)
            if (g == '0 && req[i] && i > last) g[i] = 1'b1;
        for (int i = 0; i < N_INIS; i++)
            if (g == '0 && req[i] && i <= last) g[i] = 1'b1;
        return g;
    endfunction

    // Per-initiator decode and queue status, from registers and inputs only
    always_comb begin
        for (int i = 0; i < N_INIS; i++) begin
            w_tsel[i]       = {1'b0, i_req_cfus[i*CFU_CFU_ID_W +: CFU_CFU_ID_W]} >> LEAF_CFU_ID_W;
            w_fwd_cfu[i]    = i_req_cfus[i*CFU_CFU_ID_W +: CFU_CFU_ID_W] & LEAF_MASK;
            w_bad[i]        = (w_tsel[i] >= XW'(N_TGTS));
            w_ofull[i]      = (r_ord_cnt[i] == CW'(N_REQS));
            w_oempty[i]     = (r_ord_cnt[i] == '0);
            w_ohead[i]      = r_ofifo[i][r_ord_rd[i]];
            w_resp_avail[i] = ~r_i_resp_valids[i] | i_resp_readys[i];
`ifdef SWITCH_CFU_ORD_STRICT_EN
            w_strict_ok[i]  = w_oempty[i] | (w_ohead[i] == w_tsel[i][TI_W-1:0]);
`else
            w_strict_ok[i]  = 1'b1;
`endif
            w_bad_acc[i]    = clk_en & i_req_valids[i] & w_bad[i] & w_oempty[i] & w_resp_avail[i];
        end
    end

    // Per-target eligibility, arbitration and response routing
    always_comb begin
        for (int t = 0; t < N_TGTS; t++) begin
            w_tfull[t]  = (r_tq_cnt[t] == CW'(N_REQS));
            w_tavail[t] = ~r_t_req_valids[t] | t_req_readys[t];
            w_thead[t]  = r_tq[t][r_tq_rd[t]];
            for (int i = 0; i < N_INIS; i++)
                w_elig[t][i] = clk_en & i_req_valids[i] & ~w_bad[i] & (w_tsel[i] == XW'(t))
                             & ~w_ofull[i] & ~w_tfull[t] & w_tavail[t] & w_strict_ok[i];
            w_gnt[t]     = rr_pick(w_elig[t], int'(r_rr[t]));
            w_gnt_idx[t] = '0;
            for (int i = 0; i < N_INIS; i++)
                if (w_gnt[t][i]) w_gnt_idx[t] = II_W'(i);
            w_route[t] = clk_en & t_resp_valids[t] & (r_tq_cnt[t] != '0)
                       & ~w_oempty[w_thead[t]] & (w_ohead[w_thead[t]] == TI_W'(t))
                       & w_resp_avail[w_thead[t]];
        end
    end

    // Fold per-target grants and routes back onto each initiator
    always_comb begin
        for (int i = 0; i < N_INIS; i++) begin
            w_gnt_ini[i]  = 1'b0;
            w_resp_pop[i] = 1'b0;
            for (int t = 0; t < N_TGTS; t++) begin
                w_gnt_ini[i] = w_gnt_ini[i] | w_gnt[t][i];
                if (w_route[t] && w_thead[t] == II_W'(i)) w_resp_pop[i] = 1'b1;
            end
        end
    end

    assign i_req_readys   = w_gnt_ini | w_bad_acc;
    assign t_resp_readys  = w_route;
    assign t_req_valids   = r_t_req_valids;
    assign t_req_cfus     = r_t_req_cfus;
    assign t_req_states   = r_t_req_states;
    assign t_req_funcs    = r_t_req_funcs;
    assign t_req_insns    = r_t_req_insns;
    assign t_req_data0s   = r_t_req_data0s;
    assign t_req_data1s   = r_t_req_data1s;
    assign i_resp_valids  = r_i_resp_valids;
    assign i_resp_statuss = r_i_resp_statuss;
    assign i_resp_datas   = r_i_resp_datas;

    // Queue pointers, target request registers and initiator response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_INIS; i++) begin
                r_ord_rd[i]  <= '0;
                r_ord_wr[i]  <= '0;
                r_ord_cnt[i] <= '0;
            end
            for (int t = 0; t < N_TGTS; t++) begin
                r_tq_rd[t]  <= '0;
                r_tq_wr[t]  <= '0;
                r_tq_cnt[t] <= '0;
                r_rr[t]     <= '0;
            end
            r_t_req_valids   <= '0;
            r_t_req_cfus     <= '0;
            r_t_req_states   <= '0;
            r_t_req_funcs    <= '0;
            r_t_req_insns    <= '0;
            r_t_req_data0s   <= '0;
            r_t_req_data1s   <= '0;
            r_i_resp_valids  <= '0;
            r_i_resp_statuss <= '0;
            r_i_resp_datas   <= '0;
        end else if (clk_en) begin
            for (int t = 0; t < N_TGTS; t++) begin
                if (w_gnt[t] != '0) begin
                    // A fresh grant may replace a request that handshakes this same cycle
                    r_t_req_valids[t]         <= 1'b1;
                    r_rr[t]                   <= w_gnt_idx[t];
                    r_tq[t][r_tq_wr[t]]       <= w_gnt_idx[t];
                    r_tq_wr[t]                <= r_tq_wr[t] + 1'b1;
                    for (int i = 0; i < N_INIS; i++) begin
                        if (w_gnt[t][i]) begin
                            r_t_req_cfus[t*CFU_CFU_ID_W +: CFU_CFU_ID_W]       <= w_fwd_cfu[i];
                            r_t_req_states[t*CFU_STATE_ID_W +: CFU_STATE_ID_W] <= i_req_states[i*CFU_STATE_ID_W +: CFU_STATE_ID_W];
                            r_t_req_funcs[t*CFU_FUNC_ID_W +: CFU_FUNC_ID_W]    <= i_req_funcs[i*CFU_FUNC_ID_W +: CFU_FUNC_ID_W];
                            r_t_req_insns[t*CFU_INSN_W +: CFU_INSN_W]          <= i_req_insns[i*CFU_INSN_W +: CFU_INSN_W];
                            r_t_req_data0s[t*CFU_DATA_W +: CFU_DATA_W]         <= i_req_data0s[i*CFU_DATA_W +: CFU_DATA_W];
                            r_t_req_data1s[t*CFU_DATA_W +: CFU_DATA_W]         <= i_req_data1s[i*CFU_DATA_W +: CFU_DATA_W];
                        end
                    end
                end else if (t_req_readys[t]) begin
                    r_t_req_valids[t] <= 1'b0;
                end
                if (w_route[t]) r_tq_rd[t] <= r_tq_rd[t] + 1'b1;
                r_tq_cnt[t] <= r_tq_cnt[t] + CW'(w_gnt[t] != '0) - CW'(w_route[t]);
            end
            for (int i = 0; i < N_INIS; i++) begin
                if (w_gnt_ini[i]) begin
                    r_ofifo[i][r_ord_wr[i]] <= w_tsel[i][TI_W-1:0];
                    r_ord_wr[i]             <= r_ord_wr[i] + 1'b1;
                end
                if (w_resp_pop[i]) r_ord_rd[i] <= r_ord_rd[i] + 1'b1;
                r_ord_cnt[i] <= r_ord_cnt[i] + CW'(w_gnt_ini[i]) - CW'(w_resp_pop[i]);
                if (w_bad_acc[i]) begin
                    // Out-of-range CFU ID is answered locally, never forwarded
                    r_i_resp_valids[i]                              <= 1'b1;
                    r_i_resp_statuss[i*CFU_STATUS_W +: CFU_STATUS_W] <= CFU_STATUS_W'(BAD_CFU_STATUS);
                    r_i_resp_datas[i*CFU_DATA_W +: CFU_DATA_W]       <= '0;
                end else if (w_resp_pop[i]) begin
                    r_i_resp_valids[i] <= 1'b1;
                    for (int t = 0; t < N_TGTS; t++) begin
                        if (w_route[t] && w_thead[t] == II_W'(i)) begin
                            r_i_resp_statuss[i*CFU_STATUS_W +: CFU_STATUS_W] <= t_resp_statuss[t*CFU_STATUS_W +: CFU_STATUS_W];
                            r_i_resp_datas[i*CFU_DATA_W +: CFU_DATA_W]       <= t_resp_datas[t*CFU_DATA_W +: CFU_DATA_W];
                        end
                    end
                end else if (i_resp_readys[i]) begin
                    r_i_resp_valids[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_cfu_ord.sv
// tb_switch_cfu_ord: directed bench for switch_cfu_ord with 2 initiators, 2 targets and
// LEAF_CFU_ID_W=2 (cfu 0..3 -> target 0, 4..7 -> target 1, 8..15 out of range).
// Expectations follow SWITCH_CFU_ORD_STRICT_EN when that macro is defined.
module tb_switch_cfu_ord;
    localparam int NI = 2, NT = 2, W = 4, SW = 1, FW = 10, IW = 1, DW = 32, STW = 3;

    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
    logic [NI-1:0]     i_req_valids = '0, i_req_readys;
    logic [NI*W-1:0]   i_req_cfus = '0;
    logic [NI*SW-1:0]  i_req_states = '0;
    logic [NI*FW-1:0]  i_req_funcs = '0;
    logic [NI*IW-1:0]  i_req_insns = '0;
    logic [NI*DW-1:0]  i_req_data0s = '0, i_req_data1s = '0;
    logic [NI-1:0]     i_resp_valids, i_resp_readys = '1;
    logic [NI*STW-1:0] i_resp_statuss;
    logic [NI*DW-1:0]  i_resp_datas;
    logic [NT-1:0]     t_req_valids, t_req_readys = '1;
    logic [NT*W-1:0]   t_req_cfus;
    logic [NT*SW-1:0]  t_req_states;
    logic [NT*FW-1:0]  t_req_funcs;
    logic [NT*IW-1:0]  t_req_insns;
    logic [NT*DW-1:0]  t_req_data0s, t_req_data1s;
    logic [NT-1:0]     t_resp_valids = '0, t_resp_readys;
    logic [NT*STW-1:0] t_resp_statuss = '0;
    logic [NT*DW-1:0]  t_resp_datas = '0;

    int n_tests = 0, n_fail = 0;

    switch_cfu_ord #(
        .CFU_CFU_ID_W(W), .CFU_STATE_ID_W(SW), .CFU_FUNC_ID_W(FW), .CFU_INSN_W(IW),
        .CFU_DATA_W(DW), .CFU_STATUS_W(STW), .N_INIS(NI), .N_TGTS(NT),
        .LEAF_CFU_ID_W(2), .N_REQS(4), .BAD_CFU_STATUS(2)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_req_valids(i_req_valids), .i_req_readys(i_req_readys), .i_req_cfus(i_req_cfus),
        .i_req_states(i_req_states), .i_req_funcs(i_req_funcs), .i_req_insns(i_req_insns),
        .i_req_data0s(i_req_data0s), .i_req_data1s(i_req_data1s),
        .i_resp_valids(i_resp_valids), .i_resp_readys(i_resp_readys),
        .i_resp_statuss(i_resp_statuss), .i_resp_datas(i_resp_datas),
        .t_req_valids(t_req_valids), .t_req_readys(t_req_readys), .t_req_cfus(t_req_cfus),
        .t_req_states(t_req_states), .t_req_funcs(t_req_funcs), .t_req_insns(t_req_insns),
        .t_req_data0s(t_req_data0s), .t_req_data1s(t_req_data1s),
        .t_resp_valids(t_resp_valids), .t_resp_readys(t_resp_readys),
        .t_resp_statuss(t_resp_statuss), .t_resp_datas(t_resp_datas)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_tests++; if (t_req_valids !== 2'b00) begin n_fail++; $display("FAIL rst_treq_v: got %b expected 00", t_req_valids); end
        n_tests++; if (i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL rst_iresp_v: got %b expected 00", i_resp_valids); end
        n_tests++; if (i_req_readys !== 2'b00) begin n_fail++; $display("FAIL rst_ireq_r: got %b expected 00", i_req_readys); end
        n_tests++; if (t_resp_readys !== 2'b00) begin n_fail++; $display("FAIL rst_tresp_r: got %b expected 00", t_resp_readys); end
        rst = 1'b0;
    endtask

    task automatic test_clk_en();
        clk_en = 1'b0; i_req_valids = 2'b01; i_req_cfus[3:0] = 4'd0;
        #1;
        n_tests++; if (i_req_readys !== 2'b00) begin n_fail++; $display("FAIL ce_rdy: got %b expected 00", i_req_readys); end
        step();
        n_tests++; if (t_req_valids !== 2'b00) begin n_fail++; $display("FAIL ce_treq_v: got %b expected 00", t_req_valids); end
        clk_en = 1'b1; i_req_valids = 2'b00;
    endtask

    task automatic test_multi_target();
        i_req_valids = 2'b01; i_req_cfus[3:0] = 4'd0; i_req_data0s[31:0] = 32'hA0A0;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL mt_rdy0: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_cfus[3:0] = 4'd4; i_req_data0s[31:0] = 32'hB0B0;
        #1;
        n_tests++; if (t_req_valids !== 2'b01 || t_req_data0s[31:0] !== 32'hA0A0) begin n_fail++; $display("FAIL mt_treq0: got %b/%h expected 01/a0a0", t_req_valids, t_req_data0s[31:0]); end
`ifndef SWITCH_CFU_ORD_STRICT_EN
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL mt_rdy1: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        #1;
        n_tests++; if (t_req_valids !== 2'b10 || t_req_data0s[63:32] !== 32'hB0B0 || t_req_cfus[7:4] !== 4'd0) begin n_fail++; $display("FAIL mt_treq1: got %b/%h/%h expected 10/b0b0/0", t_req_valids, t_req_data0s[63:32], t_req_cfus[7:4]); end
        // target 1 answers first; it must wait behind target 0 for initiator 0
        t_resp_valids = 2'b10; t_resp_datas[63:32] = 32'hD1D1;
        #1;
        n_tests++; if (t_resp_readys !== 2'b00) begin n_fail++; $display("FAIL mt_hold: got %b expected 00", t_resp_readys); end
        step(); step(); step();
        n_tests++; if (i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL mt_noresp: got %b expected 00", i_resp_valids); end
        t_resp_valids = 2'b11; t_resp_datas[31:0] = 32'hD0D0;
        #1;
        n_tests++; if (t_resp_readys !== 2'b01) begin n_fail++; $display("FAIL mt_route0: got %b expected 01", t_resp_readys); end
        step();
        t_resp_valids = 2'b10;
        #1;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_datas[31:0] !== 32'hD0D0) begin n_fail++; $display("FAIL mt_resp0: got %b/%h expected 01/d0d0", i_resp_valids, i_resp_datas[31:0]); end
        n_tests++; if (t_resp_readys !== 2'b10) begin n_fail++; $display("FAIL mt_route1: got %b expected 10", t_resp_readys); end
        step();
        t_resp_valids = 2'b00;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_datas[31:0] !== 32'hD1D1) begin n_fail++; $display("FAIL mt_resp1: got %b/%h expected 01/d1d1", i_resp_valids, i_resp_datas[31:0]); end
        step();
`else
        n_tests++; if (i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL st_rdy1: got %b expected 0", i_req_readys[0]); end
        step();
        n_tests++; if (i_req_readys[0] !== 1'b0 || t_req_valids !== 2'b00) begin n_fail++; $display("FAIL st_hold: got %b/%b expected 0/00", i_req_readys[0], t_req_valids); end
        t_resp_valids = 2'b01; t_resp_datas[31:0] = 32'hD0D0;
        #1;
        n_tests++; if (t_resp_readys !== 2'b01 || i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL st_route0: got %b/%b expected 01/0", t_resp_readys, i_req_readys[0]); end
        step();
        t_resp_valids = 2'b00;
        #1;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_datas[31:0] !== 32'hD0D0) begin n_fail++; $display("FAIL st_resp0: got %b/%h expected 01/d0d0", i_resp_valids, i_resp_datas[31:0]); end
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL st_rdy2: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        n_tests++; if (t_req_valids !== 2'b10 || t_req_data0s[63:32] !== 32'hB0B0) begin n_fail++; $display("FAIL st_treq1: got %b/%h expected 10/b0b0", t_req_valids, t_req_data0s[63:32]); end
        t_resp_valids = 2'b10; t_resp_datas[63:32] = 32'hD1D1;
        #1;
        n_tests++; if (t_resp_readys !== 2'b10) begin n_fail++; $display("FAIL st_route1: got %b expected 10", t_resp_readys); end
        step();
        t_resp_valids = 2'b00;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_datas[31:0] !== 32'hD1D1) begin n_fail++; $display("FAIL st_resp1: got %b/%h expected 01/d1d1", i_resp_valids, i_resp_datas[31:0]); end
        step();
`endif
        n_tests++; if (i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL mt_idle: got %b expected 00", i_resp_valids); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        // last grant on target 0 was initiator 0, so initiator 1 goes first
        i_req_valids = 2'b11; i_req_cfus = 8'h00;
        i_req_data0s[31:0] = 32'h100; i_req_data0s[63:32] = 32'h200;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            n_tests++; if (i_req_readys !== exp_g) begin n_fail++; $display("FAIL rr_gnt%0d: got %b expected %b", g, i_req_readys, exp_g); end
            if (g > 0) begin
                exp_d = (g % 2 == 1) ? 32'h200 : 32'h100;
                n_tests++; if (t_req_data0s[31:0] !== exp_d) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", g, t_req_data0s[31:0], exp_d); end
            end
            step();
        end
        i_req_valids = 2'b00;
        t_resp_valids = 2'b01;
        for (int k = 0; k < 4; k++) begin
            t_resp_datas[31:0] = 32'h50 + k;
            #1;
            n_tests++; if (t_resp_readys !== 2'b01) begin n_fail++; $display("FAIL rr_route%0d: got %b expected 01", k, t_resp_readys); end
            step();
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_d = 32'h50 + k;
            n_tests++;
            if (i_resp_valids !== exp_g || (k % 2 == 0 ? i_resp_datas[63:32] : i_resp_datas[31:0]) !== exp_d) begin
                n_fail++; $display("FAIL rr_resp%0d: got %b/%h expected %b/%h", k, i_resp_valids, i_resp_datas, exp_g, exp_d);
            end
        end
        t_resp_valids = 2'b00;
        step();
        n_tests++; if (i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL rr_idle: got %b expected 00", i_resp_valids); end
    endtask

    task automatic test_backpressure();
        i_req_valids = 2'b01; i_req_cfus[3:0] = 4'd0;
        for (int n = 0; n < 4; n++) begin
            i_req_data0s[31:0] = 32'h300 + n;
            #1;
            n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL bp_issue%0d: got %b expected 1", n, i_req_readys[0]); end
            step();
        end
        i_req_data0s[31:0] = 32'h304;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL bp_stall0: got %b expected 0", i_req_readys[0]); end
        step();
        n_tests++; if (i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL bp_stall1: got %b expected 0", i_req_readys[0]); end
        t_resp_valids = 2'b01; t_resp_datas[31:0] = 32'hA0;
        #1;
        n_tests++; if (t_resp_readys !== 2'b01 || i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL bp_popcyc: got %b/%b expected 01/0", t_resp_readys, i_req_readys[0]); end
        step();
        t_resp_valids = 2'b00;
        #1;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_datas[31:0] !== 32'hA0) begin n_fail++; $display("FAIL bp_resp: got %b/%h expected 01/a0", i_resp_valids, i_resp_datas[31:0]); end
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        t_resp_valids = 2'b01;
        for (int k = 0; k < 4; k++) begin
            t_resp_datas[31:0] = 32'hB0 + k;
            step();
            n_tests++; if (i_resp_valids[0] !== 1'b1 || i_resp_datas[31:0] !== 32'hB0 + k) begin n_fail++; $display("FAIL bp_drain%0d: got %b/%h expected 1/%h", k, i_resp_valids[0], i_resp_datas[31:0], 32'hB0 + k); end
        end
        t_resp_valids = 2'b00;
        step();
        n_tests++; if (i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL bp_idle: got %b expected 00", i_resp_valids); end
    endtask

    task automatic test_leaf_bad();
        i_req_valids = 2'b01; i_req_cfus[3:0] = 4'b0110; i_req_funcs[9:0] = 10'h155; i_req_data0s[31:0] = 32'h600;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL leaf_rdy: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        n_tests++; if (t_req_valids !== 2'b10 || t_req_cfus[7:4] !== 4'd2 || t_req_funcs[19:10] !== 10'h155) begin n_fail++; $display("FAIL leaf_fwd: got %b/%h/%h expected 10/2/155", t_req_valids, t_req_cfus[7:4], t_req_funcs[19:10]); end
        t_resp_valids = 2'b10; t_resp_statuss[5:3] = 3'd1; t_resp_datas[63:32] = 32'h7777;
        step();
        t_resp_valids = 2'b00;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_statuss[2:0] !== 3'd1 || i_resp_datas[31:0] !== 32'h7777) begin n_fail++; $display("FAIL leaf_resp: got %b/%h/%h expected 01/1/7777", i_resp_valids, i_resp_statuss[2:0], i_resp_datas[31:0]); end
        step();
        // out-of-range ID with nothing in flight: answered locally next cycle
        i_req_valids = 2'b01; i_req_cfus[3:0] = 4'b1100;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL bad_rdy: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        n_tests++; if (i_resp_valids !== 2'b01 || i_resp_statuss[2:0] !== 3'd2 || i_resp_datas[31:0] !== 32'h0 || t_req_valids !== 2'b00) begin n_fail++; $display("FAIL bad_resp: got %b/%h/%h/%b expected 01/2/0/00", i_resp_valids, i_resp_statuss[2:0], i_resp_datas[31:0], t_req_valids); end
        step();
        // out-of-range ID behind an in-flight request must wait for it
        i_req_valids = 2'b01; i_req_cfus[3:0] = 4'd0;
        step();
        i_req_cfus[3:0] = 4'b1100;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b0) begin n_fail++; $display("FAIL bad_wait: got %b expected 0", i_req_readys[0]); end
        t_resp_valids = 2'b01; t_resp_statuss[2:0] = 3'd0; t_resp_datas[31:0] = 32'h11;
        step();
        t_resp_valids = 2'b00;
        #1;
        n_tests++; if (i_req_readys[0] !== 1'b1) begin n_fail++; $display("FAIL bad_late_rdy: got %b expected 1", i_req_readys[0]); end
        step();
        i_req_valids = 2'b00;
        n_tests++; if (i_resp_statuss[2:0] !== 3'd2 || i_resp_datas[31:0] !== 32'h0) begin n_fail++; $display("FAIL bad_late_resp: got %h/%h expected 2/0", i_resp_statuss[2:0], i_resp_datas[31:0]); end
        step();
    endtask

    task automatic test_reset_midflight();
        i_req_valids = 2'b11; i_req_cfus = 8'h40; i_req_data0s = {32'h900, 32'h800};
        #1;
        n_tests++; if (i_req_readys !== 2'b11) begin n_fail++; $display("FAIL rm_both: got %b expected 11", i_req_readys); end
        step();
        i_req_valids = 2'b01;
        #1;
        n_tests++; if (i_req_readys !== 2'b01) begin n_fail++; $display("FAIL rm_third: got %b expected 01", i_req_readys); end
        step();
        i_req_valids = 2'b00; t_req_readys = 2'b00;
        n_tests++; if (t_req_valids !== 2'b01) begin n_fail++; $display("FAIL rm_pending: got %b expected 01", t_req_valids); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (t_req_valids !== 2'b00 || i_resp_valids !== 2'b00) begin n_fail++; $display("FAIL rm_cleared: got %b/%b expected 00/00", t_req_valids, i_resp_valids); end
        t_req_readys = 2'b11;
        i_req_valids = 2'b10; i_req_cfus[7:4] = 4'd0; i_req_data0s[63:32] = 32'hA00;
        #1;
        n_tests++; if (i_req_readys !== 2'b10) begin n_fail++; $display("FAIL rm_new_rdy: got %b expected 10", i_req_readys); end
        step();
        i_req_valids = 2'b00;
        n_tests++; if (t_req_valids !== 2'b01 || t_req_data0s[31:0] !== 32'hA00) begin n_fail++; $display("FAIL rm_new_fwd: got %b/%h expected 01/a00", t_req_valids, t_req_data0s[31:0]); end
        t_resp_valids = 2'b01; t_resp_datas[31:0] = 32'hCC;
        #1;
        n_tests++; if (t_resp_readys !== 2'b01) begin n_fail++; $display("FAIL rm_route: got %b expected 01", t_resp_readys); end
        step();
        t_resp_valids = 2'b00;
        n_tests++; if (i_resp_valids !== 2'b10 || i_resp_datas[63:32] !== 32'hCC) begin n_fail++; $display("FAIL rm_resp: got %b/%h expected 10/cc", i_resp_valids, i_resp_datas[63:32]); end
        step();
    endtask

    initial begin
        test_reset();
        test_clk_en();
        test_multi_target();
        test_round_robin();
        test_backpressure();
        test_leaf_bad();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
